// File: rtl/dcache_pkg.sv
// dcache_pkg: widths, FSM encoding and address helpers
// shared by the data cache controller and its tag/data array.
package dcache_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int LINE_WORDS = 4;
  localparam int WORD_BITS = 2;
  localparam int OFF_BITS = WORD_BITS + 1;
  localparam int DEF_INDEX_BITS = 8;
  localparam int DEF_TAG_BITS = ADDR_W - OFF_BITS - DEF_INDEX_BITS;
  localparam int DEF_MEM_OUTSTANDING = 4;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_WB    = 3'd1;
  localparam state_t S_FILL  = 3'd2;
  localparam state_t S_MERGE = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [LINE_WORDS-1:0][DATA_W-1:0] line_t;

  function automatic logic [WORD_BITS-1:0] addr_word(
    input logic [ADDR_W-1:0] a
  );
    return a[2:1];
  endfunction

  function automatic logic addr_misaligned(
    input logic [ADDR_W-1:0] a
  );
    return a[0];
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: direct-mapped tag/valid/dirty/data storage,
// async read by index, sync word write and full-line write.
module dcache_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int TAG_BITS   = DEF_TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx_i,
  output logic                  rd_valid_o,
  output logic                  rd_dirty_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output line_t                 rd_line_o,
  input  logic                  ww_en_i,
  input  logic [INDEX_BITS-1:0] ww_idx_i,
  input  logic [WORD_BITS-1:0]  ww_word_i,
  input  word_t                 ww_data_i,
  input  logic                  lw_en_i,
  input  logic [INDEX_BITS-1:0] lw_idx_i,
  input  logic [TAG_BITS-1:0]   lw_tag_i,
  input  line_t                 lw_line_i,
  input  logic                  lw_dirty_i
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [LINES-1:0]    dirty_q;
  logic [TAG_BITS-1:0] tag_q [LINES];
  line_t               data_q [LINES];

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_dirty_o = dirty_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_line_o  = data_q[rd_idx_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (lw_en_i) begin
      valid_q[lw_idx_i] <= 1'b1;
      dirty_q[lw_idx_i] <= lw_dirty_i;
    end else if (ww_en_i) begin
      dirty_q[ww_idx_i] <= 1'b1;
    end
  end

  // Contents are don't-care after reset; only the valid bits matter.
  always_ff @(posedge clk) begin
    if (lw_en_i) begin
      tag_q[lw_idx_i]  <= lw_tag_i;
      data_q[lw_idx_i] <= lw_line_i;
    end else if (ww_en_i) begin
      data_q[ww_idx_i][ww_word_i] <= ww_data_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate D-cache
// controller with stall/done pipeline side and req/resp memory port.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS      = DEF_INDEX_BITS,
  parameter int MEM_OUTSTANDING = DEF_MEM_OUTSTANDING
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              Rd,
  input  logic              Wr,
  output logic [DATA_W-1:0] DataOut,
  output logic              Done,
  output logic              Stall,
  output logic              CacheHit,
  output logic              err,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int TAG_BITS = ADDR_W - OFF_BITS - INDEX_BITS;
  localparam int OCNT_W   = $clog2(MEM_OUTSTANDING + 1);
  localparam logic [OCNT_W-1:0] OUT_MAX = OCNT_W'(MEM_OUTSTANDING);

  state_t                state_q, state_d;
  logic [ADDR_W-1:1]     addr_q, addr_d;
  word_t                 din_q, din_d;
  logic                  wr_q, wr_d;
  logic [WORD_BITS-1:0]  wcnt_q, wcnt_d;
  logic [WORD_BITS-1:0]  rcnt_q, rcnt_d;
  logic                  iss_done_q, iss_done_d;
  logic [OCNT_W-1:0]     outst_q, outst_d;
  line_t                 buf_q, buf_d;

  logic [INDEX_BITS-1:0] in_idx, q_idx, rd_idx;
  logic [TAG_BITS-1:0]   in_tag, q_tag;
  logic [WORD_BITS-1:0]  in_word, q_word;

  logic                  arr_valid, arr_dirty;
  logic [TAG_BITS-1:0]   arr_tag;
  line_t                 arr_line;
  logic                  ww_en, lw_en;
  line_t                 lw_line;

  logic req, illegal, hit, accept, resp;

  assign in_idx  = Addr[OFF_BITS+INDEX_BITS-1:OFF_BITS];
  assign in_tag  = Addr[ADDR_W-1:OFF_BITS+INDEX_BITS];
  assign in_word = addr_word(Addr);
  assign q_idx   = addr_q[OFF_BITS+INDEX_BITS-1:OFF_BITS];
  assign q_tag   = addr_q[ADDR_W-1:OFF_BITS+INDEX_BITS];
  assign q_word  = addr_q[2:1];
  assign rd_idx  = (state_q == S_IDLE) ? in_idx : q_idx;

  // Reset also masks the request so every output is 0 while held.
  assign req     = rst_n & (Rd | Wr);
  assign illegal = req & ((Rd & Wr) | addr_misaligned(Addr));
  assign hit     = req & ~illegal & arr_valid & (arr_tag == in_tag);

  dcache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx_i   (rd_idx),
    .rd_valid_o (arr_valid),
    .rd_dirty_o (arr_dirty),
    .rd_tag_o   (arr_tag),
    .rd_line_o  (arr_line),
    .ww_en_i    (ww_en),
    .ww_idx_i   (in_idx),
    .ww_word_i  (in_word),
    .ww_data_i  (DataIn),
    .lw_en_i    (lw_en),
    .lw_idx_i   (q_idx),
    .lw_tag_i   (q_tag),
    .lw_line_i  (lw_line),
    .lw_dirty_i (wr_q)
  );

  always_comb begin
    mem_req   = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_WB: begin
        mem_req   = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {arr_tag, q_idx, wcnt_q, 1'b0};
        mem_wdata = arr_line[wcnt_q];
      end
      S_FILL: begin
        mem_req  = ~iss_done_q & (outst_q < OUT_MAX);
        mem_addr = {q_tag, q_idx, wcnt_q, 1'b0};
      end
      default: ;
    endcase
  end

  assign accept = mem_req & mem_ready;
  // Only responses to reads issued since the last reset are counted.
  assign resp = (state_q == S_FILL) & mem_rvalid & (outst_q != '0);

  always_comb begin
    outst_d = outst_q;
    if (accept && !mem_wr) outst_d = outst_d + OCNT_W'(1);
    if (resp) outst_d = outst_d - OCNT_W'(1);
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    din_d      = din_q;
    wr_d       = wr_q;
    wcnt_d     = wcnt_q;
    rcnt_d     = rcnt_q;
    iss_done_d = iss_done_q;
    buf_d      = buf_q;
    ww_en      = 1'b0;
    lw_en      = 1'b0;
    lw_line    = buf_q;
    Done       = 1'b0;
    Stall      = 1'b0;
    CacheHit   = 1'b0;
    err        = 1'b0;
    DataOut    = '0;
    case (state_q)
      S_IDLE: begin
        if (illegal) begin
          Done = 1'b1;
          err  = 1'b1;
        end else if (hit) begin
          Done     = 1'b1;
          CacheHit = 1'b1;
          if (Rd) DataOut = arr_line[in_word];
          else    ww_en   = 1'b1;
        end else if (req) begin
          Stall      = 1'b1;
          addr_d     = Addr[ADDR_W-1:1];
          din_d      = DataIn;
          wr_d       = Wr;
          wcnt_d     = '0;
          rcnt_d     = '0;
          iss_done_d = 1'b0;
          state_d    = (arr_valid & arr_dirty) ? S_WB : S_FILL;
        end
      end
      S_WB: begin
        Stall = 1'b1;
        if (accept) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) state_d = S_FILL;
        end
      end
      S_FILL: begin
        Stall = 1'b1;
        if (accept) begin
          wcnt_d = wcnt_q + 2'd1;
          if (wcnt_q == 2'd3) iss_done_d = 1'b1;
        end
        if (resp) begin
          buf_d[rcnt_q] = mem_rdata;
          rcnt_d = rcnt_q + 2'd1;
          if (rcnt_q == 2'd3) state_d = S_MERGE;
        end
      end
      S_MERGE: begin
        Stall = 1'b1;
        lw_en = 1'b1;
        if (wr_q) lw_line[q_word] = din_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        Done    = 1'b1;
        DataOut = arr_line[q_word];
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      din_q      <= '0;
      wr_q       <= 1'b0;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      iss_done_q <= 1'b0;
      outst_q    <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      wr_q       <= wr_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      iss_done_q <= iss_done_d;
      outst_q    <= outst_d;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: scoreboard bench with a behavioural cache/memory
// model, a pipelined memory responder and randomized requests.
module tb_dcache_ctrl;

  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] DataIn = '0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, err;
  logic        mem_req, mem_wr;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;

  always #5 clk = ~clk;

  dcache_ctrl #(
    .INDEX_BITS      (8),
    .MEM_OUTSTANDING (MO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Addr       (Addr),
    .DataIn     (DataIn),
    .Rd         (Rd),
    .Wr         (Wr),
    .DataOut    (DataOut),
    .Done       (Done),
    .Stall      (Stall),
    .CacheHit   (CacheHit),
    .err        (err),
    .mem_req    (mem_req),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct packed {
    logic        err;
    logic        hit;
    logic        chk;
    logic [15:0] data;
  } exp_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } trf_t;

  typedef struct packed {
    logic [31:0] due;
    logic [15:0] data;
  } rsp_t;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  trf_t trf_q[$];
  rsp_t rsp_q[$];

  logic [15:0] ref_mem [32768];
  logic [15:0] dev_mem [32768];
  logic        ref_v [256];
  logic        ref_d [256];
  logic [4:0]  ref_t [256];
  logic [15:0] ref_line [256][4];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, expv, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Memory responder: accepts per ready mode, returns reads in order
  int          ready_mode = 0;
  int          lat_max = 1;
  int          gap = 0;
  logic [31:0] cyc = 0;
  logic [31:0] last_pres = 0;
  int          issued = 0;
  int          consumed = 0;
  logic        held_v = 1'b0;
  trf_t        held;

  always @(posedge clk) begin
    trf_t t;
    rsp_t r;
    cyc = cyc + 1;
    if (held_v && rst_n) begin
      check("hold_req", 32'(mem_req), 32'd1);
      check("hold_addr", 32'(mem_addr), 32'(held.addr));
      if (held.wr) check("hold_wdata", 32'(mem_wdata), 32'(held.data));
    end
    held_v = rst_n && mem_req && !mem_ready;
    held = '{wr: mem_wr, addr: mem_addr, data: mem_wdata};
    if (rst_n && mem_req && mem_ready) begin
      if (trf_q.size() == 0) begin
        fail_now("mem_unexpected_request");
      end else begin
        t = trf_q.pop_front();
        check("mem_wr", 32'(mem_wr), 32'(t.wr));
        check("mem_addr", 32'(mem_addr), 32'(t.addr));
        if (t.wr) check("mem_wdata", 32'(mem_wdata), 32'(t.data));
      end
      if (mem_wr) begin
        dev_mem[mem_addr[15:1]] = mem_wdata;
      end else begin
        check("outstanding_limit", 32'(issued - consumed < MO), 32'd1);
        issued++;
        r.due = cyc + 32'($urandom_range(1, lat_max));
        r.data = dev_mem[mem_addr[15:1]];
        rsp_q.push_back(r);
      end
    end
    if (mem_rvalid) consumed++;
    #1;
    mem_rvalid = 1'b0;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc &&
        cyc >= last_pres + 32'(gap)) begin
      r = rsp_q.pop_front();
      mem_rvalid = 1'b1;
      mem_rdata = r.data;
      last_pres = cyc;
    end
    case (ready_mode)
      0: mem_ready = 1'b1;
      1: mem_ready = ~mem_ready;
      default: mem_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every Done pops one expected response
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && Done) begin
      if (exp_q.size() == 0) begin
        fail_now("done_unexpected");
      end else begin
        e = exp_q.pop_front();
        check("err", 32'(err), 32'(e.err));
        check("cachehit", 32'(CacheHit), 32'(e.hit));
        check("stall_at_done", 32'(Stall), 32'd0);
        if (e.chk) check("dataout", 32'(DataOut), 32'(e.data));
        check("traffic_left", 32'(trf_q.size()), 32'd0);
      end
    end
  end

  // Reference model: cache behaviour in terms of lines and a flat memory
  task automatic model(input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
    exp_t        e;
    logic [7:0]  ix;
    logic [4:0]  tg;
    logic [1:0]  w;
    logic [15:0] ba;
    e  = '0;
    ix = a[10:3];
    tg = a[15:11];
    w  = a[2:1];
    if ((rd && wr) || a[0]) begin
      e.err = 1'b1;
      exp_q.push_back(e);
      return;
    end
    if (ref_v[ix] && ref_t[ix] == tg) begin
      e.hit = 1'b1;
      if (wr) begin
        ref_line[ix][w] = d;
        ref_d[ix] = 1'b1;
      end else begin
        e.chk = 1'b1;
        e.data = ref_line[ix][w];
      end
    end else begin
      if (ref_v[ix] && ref_d[ix]) begin
        for (int i = 0; i < 4; i++) begin
          ba = {ref_t[ix], ix, i[1:0], 1'b0};
          trf_q.push_back('{wr: 1'b1, addr: ba, data: ref_line[ix][i]});
          ref_mem[ba[15:1]] = ref_line[ix][i];
        end
      end
      for (int i = 0; i < 4; i++) begin
        ba = {tg, ix, i[1:0], 1'b0};
        trf_q.push_back('{wr: 1'b0, addr: ba, data: 16'h0});
        ref_line[ix][i] = ref_mem[ba[15:1]];
      end
      if (wr) ref_line[ix][w] = d;
      ref_v[ix] = 1'b1;
      ref_d[ix] = wr;
      ref_t[ix] = tg;
      e.chk = 1'b1;
      e.data = ref_line[ix][w];
    end
    exp_q.push_back(e);
  endtask

  // Entered and left at posedge+1
  task automatic do_req(input logic rd, input logic wr,
                        input logic [15:0] a, input logic [15:0] d,
                        input bit scramble);
    model(rd, wr, a, d);
    Rd = rd;
    Wr = wr;
    Addr = a;
    DataIn = d;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (Done) break;
      if (k > 400) begin
        fail_now("request_timeout");
        exp_q.delete();
        trf_q.delete();
        break;
      end
      @(posedge clk);
      #1;
      if (scramble) begin
        Addr = 16'($urandom);
        DataIn = 16'($urandom);
        Rd = 1'($urandom_range(0, 1));
        Wr = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk);
    #1;
    Rd = 1'b0;
    Wr = 1'b0;
    Addr = 16'($urandom);
    DataIn = 16'($urandom);
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (rsp_q.size() == 0 && !mem_rvalid) return;
      @(posedge clk);
      #1;
    end
    fail_now("drain_timeout");
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) begin
      ref_v[i] = 1'b0;
      ref_d[i] = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_done"}, 32'(Done), 32'd0);
    check({tag, "_stall"}, 32'(Stall), 32'd0);
    check({tag, "_hit"}, 32'(CacheHit), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_dataout"}, 32'(DataOut), 32'd0);
    check({tag, "_memreq"}, 32'(mem_req), 32'd0);
    check({tag, "_memwr"}, 32'(mem_wr), 32'd0);
    check({tag, "_memaddr"}, 32'(mem_addr), 32'd0);
    check({tag, "_memwdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    logic        rd, wr;
    int          r, base;
    for (int i = 0; i < 32768; i++) begin
      a = 16'(i * 40503) ^ 16'h5A5A;
      ref_mem[i] = a;
      dev_mem[i] = a;
    end
    ref_mem[8] = 16'hBEEF;
    dev_mem[8] = 16'hBEEF;
    clear_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold miss, repeat hit, store hit, dirty eviction
    ready_mode = 0;
    lat_max = 1;
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);
    do_req(1'b0, 1'b1, 16'h0012, 16'h1234, 1'b0);
    do_req(1'b1, 1'b0, 16'h0812, 16'h0, 1'b0);

    // Illegal requests leave the line untouched
    do_req(1'b1, 1'b0, 16'h0011, 16'h0, 1'b0);
    do_req(1'b1, 1'b1, 16'h0010, 16'h0, 1'b0);
    do_req(1'b1, 1'b0, 16'h0812, 16'h0, 1'b0);

    // Toggling mem_ready across writeback and fill
    ready_mode = 1;
    lat_max = 3;
    do_req(1'b0, 1'b1, 16'h0814, 16'h5555, 1'b0);
    do_req(1'b1, 1'b0, 16'h1016, 16'h0, 1'b1);
    do_req(1'b1, 1'b0, 16'h0814, 16'h0, 1'b0);
    drain();

    // Reset in the middle of a fill with responses still in flight
    ready_mode = 0;
    lat_max = 1;
    gap = 6;
    model(1'b1, 1'b0, 16'h0010, 16'h0);
    Rd = 1'b1;
    Addr = 16'h0010;
    base = consumed;
    for (int k = 0; ; k++) begin
      @(negedge clk);
      if (consumed - base >= 2) break;
      if (k > 200) begin
        fail_now("reset_setup_timeout");
        break;
      end
    end
    rst_n = 1'b0;
    Rd = 1'b0;
    #1;
    check_all_zero("midfill_reset");
    exp_q.delete();
    trf_q.delete();
    clear_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      check("late_rsp_quiet", {29'b0, Done, Stall, mem_req}, 32'd0);
      if (rsp_q.size() == 0 && !mem_rvalid) break;
    end
    @(posedge clk);
    #1;
    gap = 0;
    do_req(1'b1, 1'b0, 16'h0010, 16'h0, 1'b0);

    // Randomized traffic over a few indices and tags
    for (int n = 0; n < 400; n++) begin
      if (n % 50 == 0) begin
        ready_mode = $urandom_range(0, 2);
        lat_max = $urandom_range(1, 4);
      end
      r = $urandom_range(0, 15);
      a = {5'($urandom_range(0, 3)), 8'($urandom_range(0, 7)),
           2'($urandom_range(0, 3)), 1'b0};
      if (r == 0) a[0] = 1'b1;
      rd = (r == 1) || (r < 9);
      wr = (r == 1) || (r >= 9);
      do_req(rd, wr, a, 16'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    check("expected_left", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
